// File: rtl/aes_multi_engine_dispatch.sv
// aes_multi_engine_dispatch
// Fans the requestor's block stream across NUM_ENGINES AES pipelines in
// round-robin order and returns results in strict issue order through a
// reorder buffer (ROB).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   key_in/key_valid_in       key load request from requestor
//   data_in/valid_in/ready_out  block stream from requestor
//   eng_key_out/eng_key_valid_out  key broadcast to all engines
//   eng_data_out/eng_valid_out     per-engine issue (engine i in slice i)
//   eng_data_in/eng_valid_in       per-engine results, in order per engine
//   data_out/valid_out/ready_in    in-order results to downstream
//   inflight                  blocks issued but not yet retired
//   err_orphan                sticky: result arrived with no outstanding tag
module aes_multi_engine_dispatch #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned KEY_WIDTH   = 128,
  parameter int unsigned ROB_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [KEY_WIDTH-1:0]              key_in,
  input  logic                              key_valid_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [KEY_WIDTH-1:0]              eng_key_out,
  output logic                              eng_key_valid_out,
  output logic [NUM_ENGINES*DATA_WIDTH-1:0] eng_data_out,
  output logic [NUM_ENGINES-1:0]            eng_valid_out,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] eng_data_in,
  input  logic [NUM_ENGINES-1:0]            eng_valid_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [$clog2(ROB_DEPTH):0]        inflight,
  output logic                              err_orphan
);

  localparam int unsigned TW = $clog2(ROB_DEPTH);
  localparam int unsigned PW = TW + 1;
  localparam int unsigned RW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  // Pointers carry a wrap bit above the ROB index to tell full from empty.
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [RW-1:0]          rr_q, rr_d;
  logic [ROB_DEPTH-1:0]   rob_vld_q, rob_vld_d;
  logic [DATA_WIDTH-1:0]  rob_data_q [ROB_DEPTH];

  // Per-engine tag FIFOs: ROB slot of each outstanding block, in issue order.
  logic [TW-1:0]          tag_mem_q [NUM_ENGINES][ROB_DEPTH];
  logic [PW-1:0]          tag_wr_q  [NUM_ENGINES];
  logic [PW-1:0]          tag_rd_q  [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] tag_empty, res_hit, push;
  logic [TW-1:0]          res_tag   [NUM_ENGINES];

  logic                   key_pend_q, key_pend_d;
  logic [KEY_WIDTH-1:0]   key_hold_q, key_hold_d;
  logic [KEY_WIDTH-1:0]   eng_key_q, eng_key_d;
  logic                   eng_key_vld_q, eng_key_vld_d;
  logic [NUM_ENGINES*DATA_WIDTH-1:0] eng_data_q, eng_data_d;
  logic [NUM_ENGINES-1:0] eng_vld_q, eng_vld_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   vout_q, vout_d;
  logic                   orphan_q, orphan_d;
  logic                   live_q;

  logic [PW-1:0]          inflight_c;
  logic [TW-1:0]          hidx;
  logic                   full, accept, retire, head_rdy, key_now;
  logic [DATA_WIDTH-1:0]  head_data;

  // Tag lookup for each returning engine.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      tag_empty[i] = (tag_wr_q[i] == tag_rd_q[i]);
      res_hit[i]   = eng_valid_in[i] && !tag_empty[i];
      res_tag[i]   = tag_mem_q[i][tag_rd_q[i][TW-1:0]];
    end
  end

  // Next-state logic for issue, reorder, retire and key sequencing.
  always_comb begin
    inflight_c = tail_q - head_q;
    full       = (inflight_c == PW'(ROB_DEPTH));
    ready_out  = live_q && !full && !key_pend_q && !key_valid_in;
    accept     = valid_in && ready_out;
    hidx       = head_q[TW-1:0];

    // A result returning for the head slot retires in the same cycle.
    head_rdy  = rob_vld_q[hidx];
    head_data = rob_data_q[hidx];
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (res_hit[i] && (res_tag[i] == hidx)) begin
        head_rdy  = 1'b1;
        head_data = eng_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    retire = head_rdy && (!vout_q || ready_in);

    head_d        = head_q;
    tail_d        = tail_q;
    rr_d          = rr_q;
    rob_vld_d     = rob_vld_q;
    key_pend_d    = key_pend_q;
    key_hold_d    = key_hold_q;
    eng_key_d     = eng_key_q;
    eng_key_vld_d = 1'b0;
    eng_data_d    = eng_data_q;
    eng_vld_d     = '0;
    dout_d        = dout_q;
    vout_d        = vout_q;
    orphan_d      = orphan_q || |(eng_valid_in & tag_empty);
    push          = '0;

    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (accept && (rr_q == RW'(i))) begin
        push[i]                                  = 1'b1;
        eng_vld_d[i]                             = 1'b1;
        eng_data_d[i*DATA_WIDTH +: DATA_WIDTH]   = data_in;
      end
    end
    if (accept) begin
      tail_d = tail_q + PW'(1);
      rr_d   = (rr_q == RW'(NUM_ENGINES - 1)) ? '0 : rr_q + RW'(1);
    end

    if (retire) begin
      rob_vld_d[hidx] = 1'b0;
      dout_d          = head_data;
      vout_d          = 1'b1;
      head_d          = head_q + PW'(1);
    end else if (ready_in) begin
      vout_d = 1'b0;
    end
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (res_hit[i] && !(retire && (res_tag[i] == hidx))) begin
        rob_vld_d[res_tag[i]] = 1'b1;
      end
    end

    // Key loads only reach the engines with the pipeline empty.
    key_now = key_valid_in && (inflight_c == '0) && !key_pend_q;
    if (key_now) begin
      eng_key_d     = key_in;
      eng_key_vld_d = 1'b1;
    end else if (key_valid_in) begin
      key_hold_d = key_in;
      key_pend_d = 1'b1;
    end else if (key_pend_q && (inflight_c == '0)) begin
      eng_key_d     = key_hold_q;
      eng_key_vld_d = 1'b1;
      key_pend_d    = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      rr_q          <= '0;
      rob_vld_q     <= '0;
      key_pend_q    <= 1'b0;
      key_hold_q    <= '0;
      eng_key_q     <= '0;
      eng_key_vld_q <= 1'b0;
      eng_data_q    <= '0;
      eng_vld_q     <= '0;
      dout_q        <= '0;
      vout_q        <= 1'b0;
      orphan_q      <= 1'b0;
      live_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        tag_wr_q[i] <= '0;
        tag_rd_q[i] <= '0;
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      rr_q          <= rr_d;
      rob_vld_q     <= rob_vld_d;
      key_pend_q    <= key_pend_d;
      key_hold_q    <= key_hold_d;
      eng_key_q     <= eng_key_d;
      eng_key_vld_q <= eng_key_vld_d;
      eng_data_q    <= eng_data_d;
      eng_vld_q     <= eng_vld_d;
      dout_q        <= dout_d;
      vout_q        <= vout_d;
      orphan_q      <= orphan_d;
      live_q        <= 1'b1;
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        if (push[i])    tag_wr_q[i] <= tag_wr_q[i] + PW'(1);
        if (res_hit[i]) tag_rd_q[i] <= tag_rd_q[i] + PW'(1);
      end
    end
  end

  // Storage arrays; validity is tracked by the reset pointers and rob_vld.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (push[i]) tag_mem_q[i][tag_wr_q[i][TW-1:0]] <= tail_q[TW-1:0];
      if (res_hit[i]) rob_data_q[res_tag[i]] <= eng_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign eng_key_out       = eng_key_q;
  assign eng_key_valid_out = eng_key_vld_q;
  assign eng_data_out      = eng_data_q;
  assign eng_valid_out     = eng_vld_q;
  assign data_out          = dout_q;
  assign valid_out         = vout_q;
  assign inflight          = inflight_c;
  assign err_orphan        = orphan_q;

endmodule

// File: tb/tb_aes_multi_engine_dispatch.sv
// Bench for aes_multi_engine_dispatch: behavioural engines with per-engine
// latency, issue and output scoreboards, key/orphan/reset scenarios.
module tb_aes_multi_engine_dispatch;

  localparam int NE = 4;
  localparam int DW = 128;
  localparam int KW = 128;
  localparam int RD = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [KW-1:0]   key_in;
  logic            key_valid_in;
  logic [DW-1:0]   data_in;
  logic            valid_in;
  logic            ready_out;
  logic [KW-1:0]   eng_key_out;
  logic            eng_key_valid_out;
  logic [NE*DW-1:0] eng_data_out;
  logic [NE-1:0]   eng_valid_out;
  logic [NE*DW-1:0] eng_data_in;
  logic [NE-1:0]   eng_valid_in;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic            ready_in;
  logic [4:0]      inflight;
  logic            err_orphan;

  always #5 clk = ~clk;

  aes_multi_engine_dispatch #(
    .NUM_ENGINES(NE), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .ROB_DEPTH(RD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_valid_in(key_valid_in),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .eng_key_out(eng_key_out), .eng_key_valid_out(eng_key_valid_out),
    .eng_data_out(eng_data_out), .eng_valid_out(eng_valid_out),
    .eng_data_in(eng_data_in), .eng_valid_in(eng_valid_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  typedef struct { int e; int due; logic [DW-1:0] d; } eng_ent_t;
  typedef struct { int e; int acc; logic [DW-1:0] blk; } iss_t;

  eng_ent_t      eng_q[$];
  iss_t          iss_q[$];
  logic [DW-1:0] exp_q[$];
  int            out_cycq[$];
  int            lat[NE];
  int            cyc, rr_m, acc_n, stall_n, key_strobes, key_cyc, key_acc_n;
  int            zero_cyc, prev_infl, vo_rise_cyc, last_acc_cyc, orphan_cyc;
  logic          prev_vo;
  logic [KW-1:0] key_exp;
  int            total, bad;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in engine transform; the bench computes expected results with it.
  function automatic logic [DW-1:0] eng_fn(input logic [DW-1:0] d);
    return {d[63:0], d[127:64]} ^ {4{32'hA5C3_5A3C}};
  endfunction

  task automatic monitor();
    iss_t it;
    if (!reset_n) begin
      iss_q.delete(); exp_q.delete();
      rr_m = 0; prev_infl = 0; prev_vo = 1'b0;
      return;
    end
    if (inflight == 0 && prev_infl != 0) zero_cyc = cyc;
    prev_infl = int'(inflight);
    if (valid_out && !prev_vo) vo_rise_cyc = cyc;
    prev_vo = valid_out;
    if (eng_key_valid_out) begin
      key_strobes++; key_cyc = cyc; key_acc_n = acc_n;
      chk("key_value", eng_key_out, key_exp);
    end
    for (int e = 0; e < NE; e++) begin
      if (eng_valid_out[e]) begin
        if (iss_q.size() == 0) chk("iss_unexpected", 128'(1), 128'(0));
        else begin
          it = iss_q.pop_front();
          chk("iss_engine", 128'(e), 128'(it.e));
          chk("iss_data", eng_data_out[e*DW +: DW], it.blk);
          chk("iss_cycle", 128'(cyc), 128'(it.acc + 1));
        end
      end
    end
    if (valid_in && ready_out) begin
      it.e = rr_m; it.acc = cyc; it.blk = data_in;
      iss_q.push_back(it);
      exp_q.push_back(eng_fn(data_in));
      acc_n++; last_acc_cyc = cyc;
      rr_m = (rr_m == NE - 1) ? 0 : rr_m + 1;
    end else if (valid_in) begin
      stall_n++;
    end
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) chk("out_unexpected", 128'(1), 128'(0));
      else chk("out_data", data_out, exp_q.pop_front());
      out_cycq.push_back(cyc);
    end
  endtask

  task automatic engine();
    eng_ent_t keep[$];
    eng_ent_t ne;
    eng_valid_in = '0;
    if (!reset_n) begin eng_q.delete(); return; end
    foreach (eng_q[k]) begin
      if (eng_q[k].due == cyc) begin
        eng_valid_in[eng_q[k].e] = 1'b1;
        eng_data_in[eng_q[k].e*DW +: DW] = eng_fn(eng_q[k].d);
      end else keep.push_back(eng_q[k]);
    end
    eng_q = keep;
    if (cyc == orphan_cyc) begin
      eng_valid_in[2] = 1'b1;
      eng_data_in[2*DW +: DW] = '1;
    end
    for (int e = 0; e < NE; e++) begin
      if (eng_valid_out[e]) begin
        ne.e = e; ne.due = cyc + lat[e]; ne.d = eng_data_out[e*DW +: DW];
        eng_q.push_back(ne);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    engine();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      valid_in = 1'b1;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || inflight != 0 || valid_out) && n < maxc) begin
      tick(); n++;
    end
    chk("drain_in_time", 128'(n < maxc), 128'(1));
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, k0, i0, s0, o0, t0, n;
    total = 0; bad = 0; cyc = 0; rr_m = 0; acc_n = 0; stall_n = 0;
    key_strobes = 0; key_cyc = -1; key_acc_n = 0; zero_cyc = -1; prev_infl = 0;
    vo_rise_cyc = -1; last_acc_cyc = -1; orphan_cyc = -1; prev_vo = 1'b0; key_exp = '0;
    reset_n = 1'b0; key_in = '0; key_valid_in = 1'b0; data_in = '0; valid_in = 1'b0;
    eng_data_in = '0; eng_valid_in = '0; ready_in = 1'b1;
    set_lat(10, 10, 10, 10);

    tick(); tick();
    chk("rst_ready", 128'(ready_out), 128'(0));
    chk("rst_inflight", 128'(inflight), 128'(0));
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_eng_valid", 128'(eng_valid_out), 128'(0));
    chk("rst_orphan", 128'(err_orphan), 128'(0));
    reset_n = 1'b1;
    tick();
    chk("rdy_after_rst", 128'(ready_out), 128'(1));

    // Single block, latency 10.
    send(1);
    a0 = last_acc_cyc;
    chk("single_inflight", 128'(inflight), 128'(1));
    wait_drain(60);
    chk("single_latency", 128'(vo_rise_cyc - a0), 128'(12));
    chk("single_inflight_end", 128'(inflight), 128'(0));

    // 40 back-to-back blocks.
    i0 = out_cycq.size(); s0 = stall_n;
    send(40);
    wait_drain(100);
    chk("b2b_stalls", 128'(stall_n - s0), 128'(0));
    chk("b2b_count", 128'(out_cycq.size() - i0), 128'(40));
    if (out_cycq.size() >= i0 + 40)
      chk("b2b_rate", 128'(out_cycq[i0+39] - out_cycq[i0]), 128'(39));

    // Mixed latencies with downstream stalled until the ROB fills.
    set_lat(3, 17, 5, 9);
    ready_in = 1'b0;
    for (int k = 0; k < 30; k++) begin
      valid_in = 1'b1;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("full_ready", 128'(ready_out), 128'(0));
    chk("full_inflight", 128'(inflight), 128'(RD));
    ready_in = 1'b1;
    tick();
    chk("full_ready_back", 128'(ready_out), 128'(1));
    send(10);
    wait_drain(200);

    // Key load while idle: strobe on the next cycle.
    set_lat(20, 20, 20, 20);
    key_exp = {$urandom, $urandom, $urandom, $urandom};
    key_in = key_exp; key_valid_in = 1'b1;
    #1;
    chk("key_idle_ready", 128'(ready_out), 128'(0));
    k0 = key_strobes;
    tick();
    t0 = cyc;
    key_valid_in = 1'b0; key_in = ~key_exp;
    tick();
    chk("key_idle_strobe", 128'(key_strobes - k0), 128'(1));
    chk("key_idle_cycle", 128'(key_cyc), 128'(t0 + 1));

    // Key load with 5 blocks in flight, colliding with a valid block.
    send(5);
    chk("key_inflight5", 128'(inflight), 128'(5));
    key_exp = {$urandom, $urandom, $urandom, $urandom};
    key_in = key_exp; key_valid_in = 1'b1;
    valid_in = 1'b1; data_in = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("key_same_cycle_ready", 128'(ready_out), 128'(0));
    a0 = acc_n; k0 = key_strobes;
    tick();
    key_valid_in = 1'b0; key_in = ~key_exp;
    n = 0;
    while (key_strobes == k0 && n < 100) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      tick(); n++;
    end
    chk("key_strobe_seen", 128'(n < 100), 128'(1));
    chk("key_no_accept_pending", 128'(key_acc_n - a0), 128'(0));
    chk("key_after_drain", 128'(key_cyc), 128'(zero_cyc + 1));
    for (int k = 0; k < 5; k++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    valid_in = 1'b0;
    chk("key_once", 128'(key_strobes - k0), 128'(1));
    chk("key_accepts_resume", 128'(acc_n > key_acc_n), 128'(1));
    wait_drain(100);

    // Orphan result on engine 2.
    set_lat(4, 6, 8, 5);
    chk("orphan_before", 128'(err_orphan), 128'(0));
    orphan_cyc = cyc + 1;
    tick(); tick();
    chk("orphan_set", 128'(err_orphan), 128'(1));
    send(8);
    wait_drain(80);
    chk("orphan_sticky", 128'(err_orphan), 128'(1));

    // Reset with 8 blocks in flight.
    set_lat(20, 20, 20, 20);
    send(8);
    chk("pre_rst_inflight", 128'(inflight), 128'(8));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", 128'(valid_out), 128'(0));
    chk("mid_rst_eng_valid", 128'(eng_valid_out), 128'(0));
    chk("mid_rst_inflight", 128'(inflight), 128'(0));
    chk("mid_rst_ready", 128'(ready_out), 128'(0));
    chk("mid_rst_orphan", 128'(err_orphan), 128'(0));
    tick(); tick();
    reset_n = 1'b1;
    tick();
    o0 = out_cycq.size();
    send(1);
    chk("post_rst_inflight1", 128'(inflight), 128'(1));
    wait_drain(60);
    chk("post_rst_inflight0", 128'(inflight), 128'(0));
    chk("post_rst_outputs", 128'(out_cycq.size() - o0), 128'(1));

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
